// File: rtl/fml_arbiter_if.sv
// FML arbiter bus bundle: master-side request/ack/data and controller-side port.
// Ports: m_* (per-master slices, master i at slice i), fml_* (controller), grant.
// slave modport is the arbiter's view; master modport is the environment's view.
interface fml_arbiter_if #(
  parameter int nmasters    = 4,
  parameter int sdram_depth = 26
);
  logic [nmasters*sdram_depth-1:0] m_adr;
  logic [nmasters-1:0]             m_stb;
  logic [nmasters-1:0]             m_we;
  logic [nmasters-1:0]             m_ack;
  logic [nmasters*4-1:0]           m_sel;
  logic [nmasters*32-1:0]          m_di;
  logic [31:0]                     m_do;
  logic [sdram_depth-1:0]          fml_adr;
  logic                            fml_stb;
  logic                            fml_we;
  logic                            fml_ack;
  logic [3:0]                      fml_sel;
  logic [31:0]                     fml_di;
  logic [31:0]                     fml_do;
  logic [nmasters-1:0]             grant;

  modport slave (
    input  m_adr, m_stb, m_we, m_sel, m_di, fml_ack, fml_do,
    output m_ack, m_do, fml_adr, fml_stb, fml_we, fml_sel, fml_di, grant
  );

  modport master (
    output m_adr, m_stb, m_we, m_sel, m_di, fml_ack, fml_do,
    input  m_ack, m_do, fml_adr, fml_stb, fml_we, fml_sel, fml_di, grant
  );
endinterface

// File: rtl/fml_arbiter.sv
// Round-robin arbiter merging nmasters FML masters onto one SDRAM controller port.
// Latency: one IDLE arbitration cycle before the granted strobe reaches fml_stb; ack is combinational.
// Backpressure: masters hold m_stb until m_ack; losers wait, grant only moves in IDLE.
// Ports: sys_clk, sys_rst_n (async active-low), bus (fml_arbiter_if.slave).
module fml_arbiter #(
  parameter int nmasters    = 4,
  parameter int sdram_depth = 26,
  parameter int fml_bl      = 4
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  fml_arbiter_if.slave  bus
);

  localparam int IW = (nmasters > 1) ? $clog2(nmasters) : 1;
  localparam int CW = (fml_bl > 1) ? $clog2(fml_bl) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WDATA} state_t;

  state_t              state_q, state_d;
  logic [nmasters-1:0] grant_q, grant_d;
  logic [IW-1:0]       last_q, last_d;   // index of the current/most recent owner
  logic [CW-1:0]       cnt_q, cnt_d;     // write beats remaining after this one

  logic                pick_vld;
  logic [IW-1:0]       pick_idx;
  int                  cand;

  logic                   fml_stb;
  logic                   fml_we;
  logic [sdram_depth-1:0] fml_adr;
  logic [3:0]             fml_sel;
  logic [31:0]            fml_di;
  logic [nmasters-1:0]    m_ack;

  // Scan upward from the slot after the last owner, so the previous winner
  // ends up at lowest priority and nobody starves.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int k = 1; k <= nmasters; k++) begin
      cand = (int'(last_q) + k) % nmasters;
      if (!pick_vld && bus.m_stb[IW'(cand)]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(cand);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    fml_stb = 1'b0;
    fml_we  = 1'b0;
    fml_adr = '0;
    fml_sel = '0;
    fml_di  = '0;
    m_ack   = '0;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          last_d            = pick_idx;
          state_d           = REQ;
        end
      end
      REQ: begin
        fml_stb = bus.m_stb[last_q];
        fml_we  = bus.m_we[last_q];
        fml_adr = bus.m_adr[last_q*sdram_depth +: sdram_depth];
        if (!bus.m_stb[last_q]) begin
          // Strobe withdrawn before ack: drop the grant silently.
          grant_d = '0;
          state_d = IDLE;
        end else if (bus.fml_ack) begin
          m_ack[last_q] = 1'b1;
          if (bus.m_we[last_q]) begin
            cnt_d   = CW'(fml_bl - 1);
            state_d = WDATA;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      WDATA: begin
        // Write data/byte enables stay locked to the owner for the whole burst.
        fml_sel = bus.m_sel[last_q*4 +: 4];
        fml_di  = bus.m_di[last_q*32 +: 32];
        if (cnt_q == '0) begin
          grant_d = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(nmasters - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.fml_stb = fml_stb;
  assign bus.fml_we  = fml_we;
  assign bus.fml_adr = fml_adr;
  assign bus.fml_sel = fml_sel;
  assign bus.fml_di  = fml_di;
  assign bus.m_ack   = m_ack;
  assign bus.grant   = grant_q;
  assign bus.m_do    = bus.fml_do;

endmodule

// File: tb/tb_fml_arbiter.sv
// Directed bench for fml_arbiter: reset, read, write burst, rotation, wrap, stray ack, withdrawn strobe.
// Inputs driven 1 ns after the rising edge, outputs sampled 1 ns later.
// Every expected value below is hand-derived from the arbiter's intended behaviour.
module tb_fml_arbiter;
  localparam int NM = 4;
  localparam int DW = 26;
  localparam int BL = 4;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  fml_arbiter_if #(.nmasters(NM), .sdram_depth(DW)) bus();

  fml_arbiter #(.nmasters(NM), .sdram_depth(DW), .fml_bl(BL)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic clear_inputs;
    bus.m_adr   = '0;
    bus.m_stb   = '0;
    bus.m_we    = '0;
    bus.m_sel   = '0;
    bus.m_di    = '0;
    bus.fml_ack = 1'b0;
    bus.fml_do  = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    sys_rst_n = 1'b0;
    tick();
    tick();
    sys_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    clear_inputs();
    sys_rst_n = 1'b0;
    #3;
    n_vec++; if (bus.grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant got %b want 0000", bus.grant); end
    n_vec++; if (bus.fml_stb !== 1'b0) begin n_err++; $display("FAIL reset_fml_stb got %b want 0", bus.fml_stb); end
    n_vec++; if (bus.m_ack !== 4'b0000) begin n_err++; $display("FAIL reset_m_ack got %b want 0000", bus.m_ack); end
    n_vec++; if (bus.fml_sel !== 4'h0) begin n_err++; $display("FAIL reset_fml_sel got %h want 0", bus.fml_sel); end
    n_vec++; if (bus.fml_di !== 32'h0) begin n_err++; $display("FAIL reset_fml_di got %h want 0", bus.fml_di); end
    tick();
    sys_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read;
    do_reset();
    bus.m_adr[0 +: DW] = 26'h0001230;
    bus.m_stb = 4'b0001;
    settle();
    n_vec++; if (bus.fml_stb !== 1'b0) begin n_err++; $display("FAIL rd_idle_stb got %b want 0", bus.fml_stb); end
    tick(); // cycle 1
    n_vec++; if (bus.grant !== 4'b0001) begin n_err++; $display("FAIL rd_grant got %b want 0001", bus.grant); end
    n_vec++; if (bus.fml_stb !== 1'b1) begin n_err++; $display("FAIL rd_fml_stb got %b want 1", bus.fml_stb); end
    n_vec++; if (bus.fml_adr !== 26'h0001230) begin n_err++; $display("FAIL rd_fml_adr got %h want 0001230", bus.fml_adr); end
    n_vec++; if (bus.fml_we !== 1'b0) begin n_err++; $display("FAIL rd_fml_we got %b want 0", bus.fml_we); end
    n_vec++; if (bus.m_ack !== 4'b0000) begin n_err++; $display("FAIL rd_ack_c1 got %b want 0000", bus.m_ack); end
    tick(); // cycle 2
    bus.fml_do = 32'hCAFE_F00D;
    settle();
    n_vec++; if (bus.m_do !== 32'hCAFE_F00D) begin n_err++; $display("FAIL rd_m_do got %h want cafef00d", bus.m_do); end
    n_vec++; if (bus.m_ack !== 4'b0000) begin n_err++; $display("FAIL rd_ack_c2 got %b want 0000", bus.m_ack); end
    tick(); // cycle 3
    bus.fml_ack = 1'b1;
    settle();
    n_vec++; if (bus.m_ack !== 4'b0001) begin n_err++; $display("FAIL rd_ack_c3 got %b want 0001", bus.m_ack); end
    tick(); // cycle 4
    bus.fml_ack = 1'b0;
    bus.m_stb   = 4'b0000;
    settle();
    n_vec++; if (bus.grant !== 4'b0000) begin n_err++; $display("FAIL rd_grant_c4 got %b want 0000", bus.grant); end
    n_vec++; if (bus.m_ack !== 4'b0000) begin n_err++; $display("FAIL rd_ack_c4 got %b want 0000", bus.m_ack); end
  endtask

  task automatic setup_write_m2;
    for (int i = 0; i < NM; i++) begin
      bus.m_di[i*32 +: 32] = 32'hDEAD_0000 + i;
      bus.m_sel[i*4 +: 4]  = 4'hA;
    end
    bus.m_sel[2*4 +: 4]   = 4'hF;
    bus.m_di[2*32 +: 32]  = 32'hA5A5_0000;
    bus.m_adr[2*DW +: DW] = 26'h0ABCDE0;
    bus.m_we  = 4'b0100;
    bus.m_stb = 4'b0100;
  endtask

  task automatic test_write_burst;
    do_reset();
    setup_write_m2();
    tick(); // REQ
    n_vec++; if (bus.grant !== 4'b0100) begin n_err++; $display("FAIL wr_grant got %b want 0100", bus.grant); end
    n_vec++; if (bus.fml_we !== 1'b1) begin n_err++; $display("FAIL wr_fml_we got %b want 1", bus.fml_we); end
    n_vec++; if (bus.fml_adr !== 26'h0ABCDE0) begin n_err++; $display("FAIL wr_fml_adr got %h want 0abcde0", bus.fml_adr); end
    n_vec++; if (bus.fml_sel !== 4'h0) begin n_err++; $display("FAIL wr_sel_req got %h want 0", bus.fml_sel); end
    bus.fml_ack = 1'b1; // ack at cycle N
    settle();
    n_vec++; if (bus.m_ack !== 4'b0100) begin n_err++; $display("FAIL wr_ack got %b want 0100", bus.m_ack); end
    tick();
    bus.fml_ack = 1'b0;
    bus.m_stb   = 4'b0000;
    for (int b = 0; b < BL; b++) begin
      bus.m_di[2*32 +: 32] = 32'hA5A5_0000 + b;
      settle();
      n_vec++; if (bus.fml_sel !== 4'hF) begin n_err++; $display("FAIL wr_sel_beat%0d got %h want f", b, bus.fml_sel); end
      n_vec++; if (bus.fml_di !== 32'hA5A5_0000 + b) begin n_err++; $display("FAIL wr_di_beat%0d got %h want %h", b, bus.fml_di, 32'hA5A5_0000 + b); end
      n_vec++; if (bus.fml_stb !== 1'b0) begin n_err++; $display("FAIL wr_stb_beat%0d got %b want 0", b, bus.fml_stb); end
      tick();
    end
    settle(); // N+5
    n_vec++; if (bus.fml_sel !== 4'h0) begin n_err++; $display("FAIL wr_sel_after got %h want 0", bus.fml_sel); end
    n_vec++; if (bus.fml_di !== 32'h0) begin n_err++; $display("FAIL wr_di_after got %h want 0", bus.fml_di); end
    n_vec++; if (bus.grant !== 4'b0000) begin n_err++; $display("FAIL wr_grant_after got %b want 0000", bus.grant); end
  endtask

  task automatic test_reset_mid_burst;
    do_reset();
    setup_write_m2();
    tick(); // REQ
    bus.fml_ack = 1'b1;
    tick(); // beat 0
    bus.fml_ack = 1'b0;
    bus.m_stb   = 4'b0000;
    tick(); // beat 1
    tick(); // beat 2
    settle();
    n_vec++; if (bus.fml_sel !== 4'hF) begin n_err++; $display("FAIL rst_mid_sel_pre got %h want f", bus.fml_sel); end
    sys_rst_n = 1'b0;
    #1;
    n_vec++; if (bus.fml_sel !== 4'h0) begin n_err++; $display("FAIL rst_mid_sel got %h want 0", bus.fml_sel); end
    n_vec++; if (bus.grant !== 4'b0000) begin n_err++; $display("FAIL rst_mid_grant got %b want 0000", bus.grant); end
    tick();
    n_vec++; if (bus.fml_di !== 32'h0) begin n_err++; $display("FAIL rst_mid_di got %h want 0", bus.fml_di); end
    bus.m_we  = 4'b0000;
    bus.m_stb = 4'b1111;
    sys_rst_n = 1'b1;
    tick();
    n_vec++; if (bus.grant !== 4'b0001) begin n_err++; $display("FAIL rst_mid_first got %b want 0001", bus.grant); end
    clear_inputs();
  endtask

  task automatic test_round_robin;
    int acks [NM];
    logic [NM-1:0] exp_g;
    for (int i = 0; i < NM; i++) acks[i] = 0;
    do_reset();
    bus.m_stb   = 4'b1111;
    bus.fml_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      settle();
      n_vec++; if (bus.grant !== 4'b0000) begin n_err++; $display("FAIL rr_idle%0d grant got %b want 0000", i, bus.grant); end
      n_vec++; if (bus.m_ack !== 4'b0000) begin n_err++; $display("FAIL rr_idle%0d ack got %b want 0000", i, bus.m_ack); end
      tick();
      exp_g = NM'(1) << (i % NM);
      n_vec++; if (bus.grant !== exp_g) begin n_err++; $display("FAIL rr_grant%0d got %b want %b", i, bus.grant, exp_g); end
      n_vec++; if (bus.m_ack !== exp_g) begin n_err++; $display("FAIL rr_ack%0d got %b want %b", i, bus.m_ack, exp_g); end
      for (int m = 0; m < NM; m++) if (bus.m_ack[m] === 1'b1) acks[m]++;
      tick();
    end
    n_vec++; if (acks[0] !== 2) begin n_err++; $display("FAIL rr_cnt0 got %0d want 2", acks[0]); end
    n_vec++; if (acks[1] !== 2) begin n_err++; $display("FAIL rr_cnt1 got %0d want 2", acks[1]); end
    n_vec++; if (acks[2] !== 1) begin n_err++; $display("FAIL rr_cnt2 got %0d want 1", acks[2]); end
    n_vec++; if (acks[3] !== 1) begin n_err++; $display("FAIL rr_cnt3 got %0d want 1", acks[3]); end
    clear_inputs();
  endtask

  task automatic test_wraparound;
    do_reset();
    bus.m_stb = 4'b0010;
    tick(); // REQ for master 1
    bus.fml_ack = 1'b1;
    tick(); // IDLE, last = 1
    bus.fml_ack = 1'b0;
    bus.m_stb   = 4'b1010;
    tick();
    n_vec++; if (bus.grant !== 4'b1000) begin n_err++; $display("FAIL wrap_first got %b want 1000", bus.grant); end
    bus.fml_ack = 1'b1;
    settle();
    n_vec++; if (bus.m_ack !== 4'b1000) begin n_err++; $display("FAIL wrap_ack got %b want 1000", bus.m_ack); end
    tick();
    bus.fml_ack = 1'b0;
    settle();
    n_vec++; if (bus.grant !== 4'b0000) begin n_err++; $display("FAIL wrap_idle got %b want 0000", bus.grant); end
    tick();
    n_vec++; if (bus.grant !== 4'b0010) begin n_err++; $display("FAIL wrap_second got %b want 0010", bus.grant); end
    clear_inputs();
  endtask

  task automatic test_stray_ack;
    do_reset();
    bus.fml_ack = 1'b1;
    for (int c = 0; c < 2; c++) begin
      settle();
      n_vec++; if (bus.m_ack !== 4'b0000) begin n_err++; $display("FAIL stray_ack%0d got %b want 0000", c, bus.m_ack); end
      n_vec++; if (bus.grant !== 4'b0000) begin n_err++; $display("FAIL stray_grant%0d got %b want 0000", c, bus.grant); end
      tick();
    end
    bus.fml_ack = 1'b0;
    bus.m_stb   = 4'b0001;
    tick();
    n_vec++; if (bus.grant !== 4'b0001) begin n_err++; $display("FAIL stray_then_grant got %b want 0001", bus.grant); end
    clear_inputs();
  endtask

  task automatic test_withdraw;
    do_reset();
    bus.m_stb = 4'b0001;
    tick(); // REQ
    n_vec++; if (bus.grant !== 4'b0001) begin n_err++; $display("FAIL wd_grant got %b want 0001", bus.grant); end
    bus.m_stb = 4'b0000;
    settle();
    n_vec++; if (bus.fml_stb !== 1'b0) begin n_err++; $display("FAIL wd_fml_stb got %b want 0", bus.fml_stb); end
    n_vec++; if (bus.m_ack !== 4'b0000) begin n_err++; $display("FAIL wd_ack got %b want 0000", bus.m_ack); end
    tick();
    n_vec++; if (bus.grant !== 4'b0000) begin n_err++; $display("FAIL wd_idle got %b want 0000", bus.grant); end
    n_vec++; if (bus.fml_stb !== 1'b0) begin n_err++; $display("FAIL wd_idle_stb got %b want 0", bus.fml_stb); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_burst();
    test_reset_mid_burst();
    test_round_robin();
    test_wraparound();
    test_stray_ack();
    test_withdraw();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
